amp_init_seq: RTL
=================

AMP_INIT_SEQ -- requirements
Module: amp_init_seq

Interface
REQ-001 Parameter N_REGS, default 10, number of config bytes written per sequence (1..16).
REQ-002 Parameter T_EN_CYC, default 4096, clk cycles between enable and first write (1..65535).
REQ-003 Parameter T_MUTE_CYC, default 1024, clk cycles for settle and mute waits (1..65535).
REQ-004 Parameter REG_BASE, default 8'h00, amplifier register address of byte 0.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level; 1 = amplifier requested on.
REQ-008 reload  in  1  single-cycle pulse; rewrite config.
REQ-009 dev_addr  in  7  amplifier I2C device address.
REQ-010 cfg_data  in  8*N_REGS  config bytes; byte i = cfg_data[8i+7:8i].
REQ-011 m_req  out  1  write request to I2C master.
REQ-012 m_dev / m_reg / m_data  out  7/8/8  device, register, data of the request.
REQ-013 m_ack / m_nack  in  1/1  single-cycle completion pulses from the master.
REQ-014 amp_nenable / amp_nmute  out  1/1  active-low amplifier enable and mute.
REQ-015 busy / fault  out  1/1  sequencing in progress; sequence aborted.
REQ-016 state_mon  out  3  current state code.

Function
REQ-017 States and codes: OFF=0, PWRUP=1, WRITE=2, SETTLE=3, RUN=4, MUTE=5, FAULT=6.
REQ-018 OFF: amp_nenable=1, amp_nmute=0; start=1 -> PWRUP, timer=T_EN_CYC.
REQ-019 PWRUP: amp_nenable=0; timer decrements each cycle; at 0 -> WRITE with idx=0 and cfg_data snapshot.
REQ-020 WRITE: m_req=1, m_reg=REG_BASE+idx, m_data=snapshot byte idx, m_dev=dev_addr; fields stable while m_req=1.
REQ-021 m_ack: m_req low for 1 cycle; idx increments; after byte N_REGS-1 -> SETTLE, timer=T_MUTE_CYC.
REQ-022 m_ack and m_nack in the same cycle are treated as m_nack.
REQ-023 m_nack: go to FAULT (see REQ-032 for the retry variant).
REQ-024 SETTLE: at timer 0 -> RUN with amp_nmute=1, or -> MUTE if reload is pending.
REQ-025 RUN: amp_nmute=1; reload -> MUTE, amp_nmute=0 on the next cycle, timer=T_MUTE_CYC.
REQ-026 MUTE: at timer 0 -> WRITE, idx=0, new cfg_data snapshot.
REQ-027 reload in PWRUP, WRITE or SETTLE sets a pending flag, which is cleared on entry to MUTE; reload is ignored in OFF and FAULT.
REQ-028 start=0 in any state -> OFF next cycle; m_req drops at once; late m_ack/m_nack are ignored; start=0 takes priority over reload.
REQ-029 FAULT: amp_nenable=1, amp_nmute=0, fault=1; exits only via start=0 (-> OFF) or reset.
REQ-030 busy=1 in PWRUP, WRITE, SETTLE and MUTE; timer is 16 bits and idx is 4 bits, with no wrap beyond N_REGS-1.

Reset
REQ-031 When reset=1: state=OFF, amp_nenable=1, amp_nmute=0, m_req=0, m_dev/m_reg/m_data=0, busy=0, fault=0, state_mon=0, idx=0, timer=0, pending=0; reset mid-write abandons the request.

Configuration
REQ-032 With AMP_SEQ_RETRY_EN defined, m_nack reissues the same byte after 1 idle cycle, up to 3 retries per byte; the retry count clears on m_ack; the 4th m_nack -> FAULT. Without the macro, the first m_nack -> FAULT.

Structure
REQ-033 The state typedef amp_seq_state_t and the state codes shall reside in toi2s_pkg.
REQ-034 The wait timer shall be a sub-module seq_timer: loadable 16-bit down-counter with a zero flag.

Verification (bench params: N_REGS=10, T_EN_CYC=8, T_MUTE_CYC=4, REG_BASE=8'h10)
REQ-035 Power-up: start=1, master acks every request after 3 cycles -> amp_nenable=0 after 1 cycle; 10 requests m_reg 0x10..0x19 with matching bytes; amp_nmute=1 4 cycles after the last ack; busy=0.
REQ-036 Reload in RUN -> amp_nmute=0 next cycle; 4-cycle wait; 10 rewrites using the cfg_data value sampled at MUTE exit; back to RUN.
REQ-037 cfg_data changed mid-WRITE -> the remaining bytes still carry the snapshot value.
REQ-038 m_nack on byte 3 -> without the macro: FAULT, fault=1, amp_nenable=1. With the macro: 3 retries of byte 3, then m_ack continues to byte 4; 4 consecutive m_nack -> FAULT.
REQ-039 start=0 during WRITE with m_req=1 -> OFF next cycle, m_req=0; a following m_ack is ignored; amp_nenable=1.
REQ-040 reload during SETTLE -> pending set; state goes SETTLE -> MUTE without amp_nmute ever going to 1.

Source files
------------

// File: rtl/toi2s_pkg.sv
// Shared types and constants for the amplifier init sequencer.
// State codes are visible on state_mon, so the encoding is fixed.
package toi2s_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_MUTE   = 3'd5,
    ST_FAULT  = 3'd6
  } amp_seq_state_t;

  localparam int unsigned TMR_W     = 16;
  localparam int unsigned IDX_W     = 4;
  localparam logic [1:0]  RETRY_MAX = 2'd3;

  function automatic logic is_busy(input amp_seq_state_t s);
    return s inside {ST_PWRUP, ST_WRITE, ST_SETTLE, ST_MUTE};
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable 16-bit down-counter; stops at zero. last_o flags the cycle whose
// decrement lands on zero, so a wait of N cycles is a load of N.
module seq_timer
  import toi2s_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o,
  output logic             last_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/amp_init_seq.sv
// Amplifier power-up / config-write sequencer driving a simple I2C write master.
// Optional macro AMP_SEQ_RETRY_EN: retry a NACKed byte up to 3 times before FAULT.
module amp_init_seq
  import toi2s_pkg::*;
#(
  parameter int unsigned N_REGS     = 10,
  parameter int unsigned T_EN_CYC   = 4096,
  parameter int unsigned T_MUTE_CYC = 1024,
  parameter logic [7:0]  REG_BASE   = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  reload,
  input  logic [6:0]            dev_addr,
  input  logic [8*N_REGS-1:0]   cfg_data,
  output logic                  m_req,
  output logic [6:0]            m_dev,
  output logic [7:0]            m_reg,
  output logic [7:0]            m_data,
  input  logic                  m_ack,
  input  logic                  m_nack,
  output logic                  amp_nenable,
  output logic                  amp_nmute,
  output logic                  busy,
  output logic                  fault,
  output logic [2:0]            state_mon
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REGS - 1);
  localparam logic [TMR_W-1:0] T_EN_LD   = TMR_W'(T_EN_CYC);
  localparam logic [TMR_W-1:0] T_MUTE_LD = TMR_W'(T_MUTE_CYC);

  amp_seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  req_q, req_d;
  logic                  pend_q, pend_d;
  logic [8*N_REGS-1:0]   snap_q, snap_d;
  logic [6:0]            dev_q, dev_d;
  logic [7:0]            reg_q, reg_d;
  logic [7:0]            data_q, data_d;
`ifdef AMP_SEQ_RETRY_EN
  logic [1:0]            retry_q, retry_d;
`endif

  logic                  tmr_load, tmr_en, tmr_zero, tmr_last, tmr_done;
  logic [TMR_W-1:0]      tmr_val;
  logic                  begin_write;
  logic [7:0]            cur_byte;

  seq_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero),
    .last_o     (tmr_last)
  );

  assign tmr_done = tmr_zero | tmr_last;

  always_comb begin
    cur_byte = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (idx_q == IDX_W'(i)) cur_byte = snap_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    req_d       = req_q;
    pend_d      = pend_q;
    snap_d      = snap_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    data_d      = data_q;
`ifdef AMP_SEQ_RETRY_EN
    retry_d     = retry_q;
`endif
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_en      = 1'b0;
    begin_write = 1'b0;

    if (!start) begin
      // Dropping start abandons everything, including any outstanding request.
      state_d = ST_OFF;
      req_d   = 1'b0;
      pend_d  = 1'b0;
      idx_d   = '0;
`ifdef AMP_SEQ_RETRY_EN
      retry_d = '0;
`endif
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d  = ST_PWRUP;
          tmr_load = 1'b1;
          tmr_val  = T_EN_LD;
        end
        ST_PWRUP: begin
          if (reload) pend_d = 1'b1;
          tmr_en = 1'b1;
          if (tmr_done) begin
            state_d     = ST_WRITE;
            begin_write = 1'b1;
          end
        end
        ST_WRITE: begin
          if (reload) pend_d = 1'b1;
          if (req_q) begin
            if (m_nack) begin
              req_d = 1'b0;
`ifdef AMP_SEQ_RETRY_EN
              if (retry_q == RETRY_MAX) begin
                state_d = ST_FAULT;
              end else begin
                retry_d = retry_q + 1'b1;
              end
`else
              state_d = ST_FAULT;
`endif
            end else if (m_ack) begin
              req_d = 1'b0;
`ifdef AMP_SEQ_RETRY_EN
              retry_d = '0;
`endif
              if (idx_q == LAST_IDX) begin
                state_d  = ST_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = T_MUTE_LD;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end else begin
            // Idle gap after a completion: issue the byte at idx_q.
            req_d  = 1'b1;
            dev_d  = dev_addr;
            reg_d  = REG_BASE + 8'(idx_q);
            data_d = cur_byte;
          end
        end
        ST_SETTLE: begin
          if (reload) pend_d = 1'b1;
          tmr_en = 1'b1;
          if (tmr_done) begin
            if (pend_q || reload) begin
              state_d  = ST_MUTE;
              pend_d   = 1'b0;
              tmr_load = 1'b1;
              tmr_val  = T_MUTE_LD;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (reload) begin
            state_d  = ST_MUTE;
            pend_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = T_MUTE_LD;
          end
        end
        ST_MUTE: begin
          pend_d = 1'b0;
          tmr_en = 1'b1;
          if (tmr_done) begin
            state_d     = ST_WRITE;
            begin_write = 1'b1;
          end
        end
        ST_FAULT: begin
          req_d = 1'b0;
        end
        default: begin
          state_d = ST_OFF;
          req_d   = 1'b0;
        end
      endcase

      // First request goes out in the same cycle as the snapshot, from cfg_data directly.
      if (begin_write) begin
        snap_d  = cfg_data;
        idx_d   = '0;
        req_d   = 1'b1;
        dev_d   = dev_addr;
        reg_d   = REG_BASE;
        data_d  = cfg_data[7:0];
`ifdef AMP_SEQ_RETRY_EN
        retry_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      snap_q  <= '0;
      dev_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
`ifdef AMP_SEQ_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      snap_q  <= snap_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
`ifdef AMP_SEQ_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign m_req       = req_q;
  assign m_dev       = dev_q;
  assign m_reg       = reg_q;
  assign m_data      = data_q;
  assign amp_nenable = (state_q == ST_OFF) || (state_q == ST_FAULT);
  assign amp_nmute   = (state_q == ST_RUN);
  assign busy        = is_busy(state_q);
  assign fault       = (state_q == ST_FAULT);
  assign state_mon   = state_q;

endmodule
